// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button front end: key vector width, the
// debounce FSM state encoding, and the one-hot test used to accept a key.
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int KEY_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } key_state_t;

  // True when exactly one bit of vec is set.
  function automatic logic is_onehot(input logic [KEY_W-1:0] vec);
    logic [KEY_W-1:0] vec_m1;
    vec_m1 = vec - KEY_W'(1);
    return (vec != '0) && ((vec & vec_m1) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for quasi-static asynchronous inputs (buttons,
// straps). Each bit is synchronized independently; no coherency between bits
// is implied.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset, clears both stages
//   d    in   [W-1:0] asynchronous input
//   q    out  [W-1:0] synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_onehot_debounce.sv
// -----------------------------------------------------------------------------
// key_onehot_debounce
// Cleans eight raw push-button lines for the 8-to-3 encoder. Buttons are
// synchronized, debounced, and any stable chord of more than one key is
// rejected, so oData is always all-zero or exactly one-hot.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no key activity, waiting for any nonzero pattern
//   CHECK   | pattern captured, counting stable cycles before deciding
//   PRESSED | single key accepted and presented on oData
//   RELEASE | waiting for a clean, debounced all-released period
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   iKey    in   [7:0] raw button levels, async to clk, 1 = pressed
//   oData   out  [7:0] debounced key vector, 0 or one-hot
//   oValid  out  one-cycle pulse when a key is accepted into oData
//   oMulti  out  one-cycle pulse when a stable multi-key chord is rejected
//   oBusy   out  high whenever the FSM is not in IDLE
//
// DEBOUNCE_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module key_onehot_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] iKey,
  output logic [KEY_W-1:0] oData,
  output logic             oValid,
  output logic             oMulti,
  output logic             oBusy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [KEY_W-1:0] ks;

  key_state_t       state_q,  state_d;
  logic [KEY_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [KEY_W-1:0] data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             multi_q,  multi_d;
  logic             busy_q,   busy_d;

  sync_2ff #(
    .W (KEY_W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (iKey),
    .q   (ks)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    multi_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ks != '0) begin
          sample_d = ks;
          cnt_d    = '0;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (ks != sample_q) begin
          // Any bounce restarts the stability count on the new pattern.
          sample_d = ks;
          cnt_d    = '0;
        end else if (cnt_q != CNT_TC) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (sample_q == '0) begin
          // Pattern settled back to nothing: a glitch, drop it silently.
          state_d = IDLE;
        end else if (is_onehot(sample_q)) begin
          data_d  = sample_q;
          valid_d = 1'b1;
          state_d = PRESSED;
        end else begin
          data_d  = '0;
          multi_d = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      PRESSED: begin
        // Extra keys or a swap to another key are ignored until release.
        if (ks == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (ks != '0) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_TC) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          data_d  = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
      busy_q   <= busy_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oMulti = multi_q;
  assign oBusy  = busy_q;

endmodule
